// File: rtl/seg_scan_mux_pkg.sv
// ============================================================================
// Module      : seg_scan_mux_pkg
// Description : Shared constants and types for the multiplexed 7-segment
//               display stage and the clock top that feeds it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_mux_pkg;

  // All segments dark on an active-low bus
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Defaults shared with the clock top (1 kHz per digit at 50 MHz)
  localparam int DEF_NUM_DIGITS   = 6;
  localparam int DEF_SCAN_DIV     = 50000;
  localparam int DEF_BLANK_CYCLES = 500;

  // Phase within one digit slot
  localparam int PHASE_W = 1;
  typedef enum logic [PHASE_W-1:0] {
    PH_DEAD  = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

`default_nettype wire

// File: rtl/seg_scan_mux_decoder.sv
// ============================================================================
// Module      : seg_scan_mux_decoder
// Description : BCD to 7-segment decoder, active-low outputs.
//               seg_n_o[0]=a ... seg_n_o[6]=g. Non-BCD codes give all dark.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux_decoder
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Glyph lookup, bit order {g,f,e,d,c,b,a}, 0 = segment lit
  always_comb begin
    seg_n_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_n_o = 7'h40;
      4'd1:    seg_n_o = 7'h79;
      4'd2:    seg_n_o = 7'h24;
      4'd3:    seg_n_o = 7'h30;
      4'd4:    seg_n_o = 7'h19;
      4'd5:    seg_n_o = 7'h12;
      4'd6:    seg_n_o = 7'h02;
      4'd7:    seg_n_o = 7'h78;
      4'd8:    seg_n_o = 7'h00;
      4'd9:    seg_n_o = 7'h10;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexes NUM_DIGITS BCD digits onto one shared
//               active-low 7-segment bus with per-digit enables. Includes a
//               scan prescaler, a dead time at the start of every slot and a
//               per-frame snapshot of the digit data so a frame never tears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_bcd,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     dig_en_n,
  output logic                      frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  // High for the first cycle after reset: takes the opening snapshot while
  // holding the scan at slot 0, count 0, so the first frame is full length
  logic                    start_q;
  logic                    wrap;
  logic                    take_snap;
  phase_e                  phase;

  // Frame snapshot
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_blank_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;

  // Muxed digit for the current slot
  logic [3:0]              w_digit;
  logic                    w_blank;
  logic                    w_dp;
  logic [6:0]              w_dec_seg_n;

  // Registered outputs
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   dig_en_n_q, dig_en_n_d;
  logic                    frame_tick_q;

  // State register: prescaler, digit index, snapshot and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      start_q       <= 1'b1;
      snap_digits_q <= '0;
      snap_blank_q  <= '0;
      snap_dp_q     <= '0;
      seg_n_q       <= SEG_OFF;
      dp_n_q        <= 1'b1;
      dig_en_n_q    <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      start_q      <= 1'b0;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      dig_en_n_q   <= dig_en_n_d;
      frame_tick_q <= take_snap;
      if (take_snap) begin
        snap_digits_q <= digits_bcd;
        snap_blank_q  <= blank_mask;
        snap_dp_q     <= dp_mask;
      end
    end
  end

  // Next-state: count within the slot, step the digit, wrap by compare
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (start_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    take_snap = start_q | wrap;
  end

  // Select the snapshot entry for the active slot
  always_comb begin
    w_digit = '0;
    w_blank = 1'b0;
    w_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_digit = snap_digits_q[4*i +: 4];
        w_blank = snap_blank_q[i];
        w_dp    = snap_dp_q[i];
      end
    end
  end

  // Single shared decoder on the muxed digit
  seg_scan_mux_decoder u_decoder7segment (
    .bcd_i   (w_digit),
    .seg_n_o (w_dec_seg_n)
  );

  // Output decode: dead time first, then drive the active digit
  always_comb begin
    phase      = (start_q || (cnt_q < CNT_DEAD)) ? PH_DEAD : PH_DRIVE;
    seg_n_d    = SEG_OFF;
    dp_n_d     = 1'b1;
    dig_en_n_d = '1;
    if (phase == PH_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_en_n_d[i] = (idx_q != IDX_W'(i));
      end
      // Blanked digits keep their enable so brightness timing stays uniform
      if (!w_blank) begin
        seg_n_d = (w_digit > BCD_MAX) ? SEG_OFF : w_dec_seg_n;
        dp_n_d  = ~w_dp;
      end
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign dig_en_n   = dig_en_n_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Self-checking bench for seg_scan_mux (SCAN_DIV=8,
//               BLANK_CYCLES=2, NUM_DIGITS=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_mux;

  localparam int ND    = 6;
  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = SCAN * ND;

  logic            clk;
  logic            rst;
  logic [4*ND-1:0] digits_bcd;
  logic [ND-1:0]   blank_mask;
  logic [ND-1:0]   dp_mask;
  logic [6:0]      seg_n;
  logic            dp_n;
  logic [ND-1:0]   dig_en_n;
  logic            frame_tick;

  int vectors    = 0;
  int miscompares = 0;

  seg_scan_mux #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SCAN),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_bcd (digits_bcd),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_en_n   (dig_en_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments per digit value, bit order {g,f,e,d,c,b,a}, 1 = lit
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'b0111111;
      4'd1: glyph = 7'b0000110;
      4'd2: glyph = 7'b1011011;
      4'd3: glyph = 7'b1001111;
      4'd4: glyph = 7'b1100110;
      4'd5: glyph = 7'b1101101;
      4'd6: glyph = 7'b1111101;
      4'd7: glyph = 7'b0000111;
      4'd8: glyph = 7'b1111111;
      4'd9: glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Model: n = clock edges since reset release. Edge 1 takes the first
  // snapshot and pulses frame_tick; from then on state index m = edge - 2
  // walks slots of SCAN cycles, frames of FRAME cycles.
  int            n;
  bit            exp_valid = 1'b0;
  logic [6:0]    e_seg;
  logic          e_dp;
  logic [ND-1:0] e_en;
  logic          e_tick;
  logic [4*ND-1:0] m_dig;
  logic [ND-1:0]   m_blank;
  logic [ND-1:0]   m_dp;

  always @(posedge clk) begin
    int m, c, k;
    logic [6:0]    s;
    logic          p;
    logic [ND-1:0] en;
    logic [3:0]    d;
    if (rst) begin
      n         <= 0;
      e_seg     <= 7'h7F;
      e_dp      <= 1'b1;
      e_en      <= '1;
      e_tick    <= 1'b0;
      exp_valid <= 1'b1;
    end else begin
      s  = 7'h7F;
      p  = 1'b1;
      en = '1;
      if (n >= 1) begin
        m = n - 1;
        c = m % SCAN;
        k = (m / SCAN) % ND;
        if (c >= BLANK) begin
          en = ~(6'b000001 << k);
          d  = m_dig[4*k +: 4];
          if (!m_blank[k]) begin
            s = ~glyph(d);
            p = ~m_dp[k];
          end
        end
      end
      e_seg  <= s;
      e_dp   <= p;
      e_en   <= en;
      e_tick <= (n % FRAME == 0);
      if (n % FRAME == 0) begin
        m_dig   <= digits_bcd;
        m_blank <= blank_mask;
        m_dp    <= dp_mask;
      end
      n <= n + 1;
    end
  end

  // Compare every cycle once the model is defined
  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if ({seg_n, dp_n, dig_en_n, frame_tick} !== {e_seg, e_dp, e_en, e_tick}) begin
        miscompares++;
        $display("FAIL model n=%0d: got seg_n=%h dp_n=%b dig_en_n=%b frame_tick=%b, expected seg_n=%h dp_n=%b dig_en_n=%b frame_tick=%b",
                 n, seg_n, dp_n, dig_en_n, frame_tick, e_seg, e_dp, e_en, e_tick);
      end
    end
  end

  // Hand-computed literal check of {seg_n, dp_n, dig_en_n, frame_tick}
  task automatic lit(input string name, input logic [6:0] s, input logic p,
                     input logic [ND-1:0] en, input logic t);
    vectors++;
    if ({seg_n, dp_n, dig_en_n, frame_tick} !== {s, p, en, t}) begin
      miscompares++;
      $display("FAIL %s: got seg_n=%h dp_n=%b dig_en_n=%b frame_tick=%b, expected seg_n=%h dp_n=%b dig_en_n=%b frame_tick=%b",
               name, seg_n, dp_n, dig_en_n, frame_tick, s, p, en, t);
    end
  endtask

  // Advance to the negedge following edge t since release (bounded)
  task automatic goto(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) begin
      vectors++;
      miscompares++;
      $display("FAIL goto: got n=%0d, expected n=%0d", n, t);
    end
  endtask

  initial begin
    rst        = 1'b1;
    digits_bcd = 24'h123456;
    blank_mask = '0;
    dp_mask    = '0;
    repeat (3) @(negedge clk);
    lit("reset", 7'h7F, 1'b1, 6'b111111, 1'b0);
    rst = 1'b0;

    // First frame: tick one cycle after release, slot 0 "6", slot 5 "1"
    @(negedge clk);
    lit("first_tick", 7'h7F, 1'b1, 6'b111111, 1'b1);
    goto(2);  lit("tick_len", 7'h7F, 1'b1, 6'b111111, 1'b0);
    goto(3);  lit("slot0_dead", 7'h7F, 1'b1, 6'b111111, 1'b0);
    goto(4);  lit("slot0_six", 7'h02, 1'b1, 6'b111110, 1'b0);
    goto(12); lit("slot1_five", 7'h12, 1'b1, 6'b111101, 1'b0);
    goto(44); lit("slot5_one", 7'h79, 1'b1, 6'b011111, 1'b0);
    goto(49); lit("frame_48", 7'h79, 1'b1, 6'b011111, 1'b1);

    // Mid-frame data change stays invisible until the next frame
    goto(68); digits_bcd = 24'h999999;
    goto(76);  lit("no_tear_slot3", 7'h30, 1'b1, 6'b110111, 1'b0);
    goto(92);  lit("no_tear_slot5", 7'h79, 1'b1, 6'b011111, 1'b0);
    goto(97);  lit("frame2_tick", 7'h79, 1'b1, 6'b011111, 1'b1);
    goto(100); lit("frame2_nine", 7'h10, 1'b1, 6'b111110, 1'b0);

    // Blanking, decimal point and illegal BCD in the next frame
    digits_bcd = 24'h99999C;
    blank_mask = 6'b100000;
    dp_mask    = 6'b000100;
    goto(148); lit("illegal_bcd", 7'h7F, 1'b1, 6'b111110, 1'b0);
    goto(156); lit("slot1_plain", 7'h10, 1'b1, 6'b111101, 1'b0);
    goto(164); lit("slot2_dp", 7'h10, 1'b0, 6'b111011, 1'b0);
    goto(188); lit("slot5_blank", 7'h7F, 1'b1, 6'b011111, 1'b0);

    // Reset mid-slot 3, then restart at slot 0 with a fresh snapshot
    goto(220);
    rst        = 1'b1;
    digits_bcd = 24'h123456;
    blank_mask = '0;
    dp_mask    = '0;
    @(negedge clk);
    lit("mid_reset_dark", 7'h7F, 1'b1, 6'b111111, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    lit("restart_tick", 7'h7F, 1'b1, 6'b111111, 1'b1);
    goto(4);  lit("restart_slot0", 7'h02, 1'b1, 6'b111110, 1'b0);
    goto(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
